maze_dfs_sequencer: RTL and testbench

MAZE_DFS_SEQUENCER -- requirements
Module: maze_dfs_sequencer

---
 rtl/maze_pkg.sv | 27 ++
 rtl/maze_nbr_calc.sv | 48 ++++
 rtl/maze_dfs_sequencer.sv | 177 +++++++++++++++++
 tb/tb_maze_dfs_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze depth-first search sequencer.
package maze_pkg;

  localparam int GRID_DIM = 16;

  typedef logic [7:0] loc_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_MARK,
    S_CHECK,
    S_READ,
    S_EVAL,
    S_ADVANCE,
    S_BACKTRACK,
    S_DONE,
    S_FAIL
  } state_t;

  // Direction scan order; DIR_NONE means every direction has been tried.
  localparam logic [2:0] DIR_EAST  = 3'd0;
  localparam logic [2:0] DIR_SOUTH = 3'd1;
  localparam logic [2:0] DIR_WEST  = 3'd2;
  localparam logic [2:0] DIR_NORTH = 3'd3;
  localparam logic [2:0] DIR_NONE  = 3'd4;

endpackage

// File: rtl/maze_nbr_calc.sv
// Neighbour address calculator: given a cell {row, col} and a direction,
// returns the adjacent cell and whether it lies inside the grid (no wrap).
module maze_nbr_calc
  import maze_pkg::*;
(
  input  loc_t       loc,
  input  logic [2:0] dir,
  output loc_t       nbr,
  output logic       in_range
);

  localparam logic [3:0] EDGE_HI = 4'(GRID_DIM - 1);

  logic [3:0] row;
  logic [3:0] col;

  assign row = loc[7:4];
  assign col = loc[3:0];

  // Step one cell in the requested direction, flagging grid-edge crossings.
  always_comb begin
    nbr      = loc;
    in_range = 1'b0;
    case (dir)
      DIR_EAST: begin
        nbr      = {row, col + 4'd1};
        in_range = (col != EDGE_HI);
      end
      DIR_SOUTH: begin
        nbr      = {row + 4'd1, col};
        in_range = (row != EDGE_HI);
      end
      DIR_WEST: begin
        nbr      = {row, col - 4'd1};
        in_range = (col != 4'd0);
      end
      DIR_NORTH: begin
        nbr      = {row - 4'd1, col};
        in_range = (row != 4'd0);
      end
      default: begin
        nbr      = loc;
        in_range = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/maze_dfs_sequencer.sv
// Depth-first maze search sequencer. Walks a 16x16 grid held in an external
// 1-bit memory, marking visited cells and keeping the return path on an
// external stack.
// Optional build macro MAZE_DFS_STEP_CNT_EN adds the step_cnt output, a
// saturating count of ADVANCE and BACKTRACK cycles since the last start.
//
// state     | meaning
// IDLE      | waiting for start
// MARK      | write 1 to the current cell, test for goal
// CHECK     | pick next direction, skip off-grid neighbours
// READ      | read neighbour cell
// EVAL      | neighbour blocked -> next dir, free -> advance
// ADVANCE   | push current cell, step into neighbour
// BACKTRACK | pop previous cell, rescan from dir 0
// DONE      | goal reached
// FAIL      | stack empty on backtrack or full on advance
module maze_dfs_sequencer
  import maze_pkg::*;
#(
  parameter loc_t START_LOC = 8'h00,
  parameter loc_t GOAL_LOC  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output loc_t        mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_wdata,
  input  logic        mem_rdata,
  output logic        stk_push,
  output logic        stk_pop,
  output loc_t        stk_din,
  input  loc_t        stk_dout,
  input  logic        stk_empty,
  input  logic        stk_full,
  output loc_t        cur_loc,
  output logic        move,
  output logic        busy,
  output logic        done,
`ifdef MAZE_DFS_STEP_CNT_EN
  output logic [15:0] step_cnt,
`endif
  output logic        fail
);

  state_t     state;
  logic [2:0] dir;
  loc_t       nbr;
  logic       in_range;
  logic       start_accept;

  maze_nbr_calc u_nbr_calc (
    .loc      (cur_loc),
    .dir      (dir),
    .nbr      (nbr),
    .in_range (in_range)
  );

  assign start_accept = start &&
                        ((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));

  // Marked cells are always written as visited.
  assign mem_wdata = 1'b1;

  // Memory and stack strobes decode from the state; at most one is ever set
  // because each belongs to a different state.
  always_comb begin
    mem_rd   = (state == S_READ);
    mem_wr   = (state == S_MARK);
    stk_push = (state == S_ADVANCE) && !stk_full;
    stk_pop  = (state == S_BACKTRACK) && !stk_empty;
    move     = (state == S_ADVANCE) && !stk_full;
    mem_addr = '0;
    if (state == S_MARK) begin
      mem_addr = cur_loc;
    end else if (state == S_READ) begin
      mem_addr = nbr;
    end
    stk_din = ((state == S_ADVANCE) && !stk_full) ? cur_loc : '0;
  end

  // Search FSM with registered location, direction and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cur_loc <= START_LOC;
      dir     <= DIR_EAST;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start_accept) begin
            state   <= S_MARK;
            cur_loc <= START_LOC;
            dir     <= DIR_EAST;
            busy    <= 1'b1;
            done    <= 1'b0;
            fail    <= 1'b0;
          end
        end
        S_MARK: begin
          if (cur_loc == GOAL_LOC) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (dir == DIR_NONE) begin
            state <= S_BACKTRACK;
          end else if (!in_range) begin
            dir <= dir + 3'd1;
          end else begin
            state <= S_READ;
          end
        end
        S_READ: begin
          state <= S_EVAL;
        end
        S_EVAL: begin
          if (mem_rdata) begin
            dir   <= dir + 3'd1;
            state <= S_CHECK;
          end else begin
            state <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          if (stk_full) begin
            state <= S_FAIL;
            busy  <= 1'b0;
            fail  <= 1'b1;
          end else begin
            cur_loc <= nbr;
            dir     <= DIR_EAST;
            state   <= S_MARK;
          end
        end
        S_BACKTRACK: begin
          if (stk_empty) begin
            state <= S_FAIL;
            busy  <= 1'b0;
            fail  <= 1'b1;
          end else begin
            cur_loc <= stk_dout;
            dir     <= DIR_EAST;
            state   <= S_CHECK;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAZE_DFS_STEP_CNT_EN
  // Saturating count of ADVANCE/BACKTRACK cycles, cleared by each accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (start_accept) begin
      step_cnt <= '0;
    end else if (((state == S_ADVANCE) || (state == S_BACKTRACK)) &&
                 (step_cnt != 16'hFFFF)) begin
      step_cnt <= step_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_maze_dfs_sequencer.sv
// Bench for maze_dfs_sequencer: behavioural maze memory and stack, plus a
// cell-level depth-first search reference model.
module tb_maze_dfs_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  mem_addr;
  logic        mem_rd, mem_wr, mem_wdata;
  logic        mem_rdata = 1'b0;
  logic        stk_push, stk_pop;
  logic [7:0]  stk_din, stk_dout;
  logic        stk_empty, stk_full;
  logic [7:0]  cur_loc;
  logic        move, busy, done, fail;
`ifdef MAZE_DFS_STEP_CNT_EN
  logic [15:0] step_cnt;
`endif

  always #5 clk = ~clk;

  maze_dfs_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .cur_loc   (cur_loc),
    .move      (move),
    .busy      (busy),
    .done      (done),
`ifdef MAZE_DFS_STEP_CNT_EN
    .step_cnt  (step_cnt),
`endif
    .fail      (fail)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // ---------------- environment: maze memory, stack, monitors -------------
  logic       maze[256];
  logic       maze_init[256];
  logic [7:0] stk_mem[256];
  int         sp = 0;
  int         stk_depth = 256;
  logic       env_clr = 1'b1;
  int         mv_cnt, pop_cnt, push_cnt, rd_cnt, onehot_bad, flag_bad, wdata_bad;
  logic [7:0] obs_marks[$];

  assign stk_empty = (sp == 0);
  assign stk_full  = (sp >= stk_depth);
  assign stk_dout  = (sp > 0) ? stk_mem[8'(sp - 1)] : 8'h00;

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 256; i++) maze[i] <= maze_init[i];
      sp         <= 0;
      mv_cnt     <= 0;
      pop_cnt    <= 0;
      push_cnt   <= 0;
      rd_cnt     <= 0;
      onehot_bad <= 0;
      flag_bad   <= 0;
      wdata_bad  <= 0;
      obs_marks.delete();
    end else begin
      if (mem_rd) mem_rdata <= maze[mem_addr];
      if (mem_wr) begin
        maze[mem_addr] <= mem_wdata;
        obs_marks.push_back(mem_addr);
        if (!mem_wdata) wdata_bad <= wdata_bad + 1;
      end
      if (stk_push) begin
        stk_mem[8'(sp)] <= stk_din;
        sp <= sp + 1;
        push_cnt <= push_cnt + 1;
      end else if (stk_pop && sp > 0) begin
        sp <= sp - 1;
      end
      if (stk_pop) pop_cnt <= pop_cnt + 1;
      if (move) mv_cnt <= mv_cnt + 1;
      if (mem_rd) rd_cnt <= rd_cnt + 1;
      if ((32'(mem_rd) + 32'(mem_wr) + 32'(stk_push) + 32'(stk_pop)) > 1)
        onehot_bad <= onehot_bad + 1;
      if (done && fail) flag_bad <= flag_bad + 1;
    end
  end

  // ---------------- reference model ---------------------------------------
  int         exp_res;   // 1 = reaches goal, 2 = fails
  int         exp_moves, exp_pops, exp_steps;
  logic [7:0] exp_cur;
  logic [7:0] exp_marks[$];

  task automatic ref_search(input int depth);
    bit         m[256];
    logic [7:0] stk[$];
    int cur, r, c, nr, nc, nxt;
    bit mark, found;
    for (int i = 0; i < 256; i++) m[i] = maze_init[i];
    exp_marks.delete();
    exp_moves = 0; exp_pops = 0; exp_steps = 0; exp_res = 0;
    cur = 0; nxt = 0; mark = 1;
    forever begin
      if (mark) begin
        m[8'(cur)] = 1;
        exp_marks.push_back(8'(cur));
        if (cur == 255) begin exp_res = 1; break; end
      end
      found = 0;
      r = cur / 16;
      c = cur % 16;
      for (int d = 0; d < 4; d++) begin
        if (!found) begin
          nr = r + ((d == 1) ? 1 : (d == 3) ? -1 : 0);
          nc = c + ((d == 0) ? 1 : (d == 2) ? -1 : 0);
          if (nr >= 0 && nr < 16 && nc >= 0 && nc < 16 && !m[8'(nr * 16 + nc)]) begin
            found = 1;
            nxt = nr * 16 + nc;
          end
        end
      end
      exp_steps++;
      if (found) begin
        if (stk.size() >= depth) begin exp_res = 2; break; end
        stk.push_back(8'(cur));
        exp_moves++;
        cur = nxt;
        mark = 1;
      end else begin
        if (stk.size() == 0) begin exp_res = 2; break; end
        cur = int'(stk.pop_back());
        exp_pops++;
        mark = 0;
      end
    end
    exp_cur = 8'(cur);
  endtask

  // ---------------- stimulus helpers --------------------------------------
  task automatic maze_fill(input bit v);
    for (int i = 0; i < 256; i++) maze_init[i] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_env(input int depth);
    stk_depth = depth;
    env_clr = 1'b1;
    @(negedge clk);
    env_clr = 1'b0;
  endtask

  task automatic run_case(input string tag, input int depth);
    int cyc;
    int diff;
    ref_search(depth);
    load_env(depth);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(done || fail) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " timeout"}, int'(cyc >= 20000), 0);
    chk({tag, " done"}, int'(done), int'(exp_res == 1));
    chk({tag, " fail"}, int'(fail), int'(exp_res == 2));
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " moves"}, mv_cnt, exp_moves);
    chk({tag, " pushes"}, push_cnt, exp_moves);
    chk({tag, " pops"}, pop_cnt, exp_pops);
    chk({tag, " cur_loc"}, int'(cur_loc), int'(exp_cur));
    chk({tag, " marks"}, obs_marks.size(), exp_marks.size());
    diff = 0;
    for (int i = 0; i < obs_marks.size() && i < exp_marks.size(); i++)
      if (obs_marks[i] != exp_marks[i]) diff++;
    chk({tag, " mark_seq"}, diff, 0);
`ifdef MAZE_DFS_STEP_CNT_EN
    chk({tag, " step_cnt"}, int'(step_cnt), exp_steps);
`endif
    chk({tag, " strobe_onehot"}, onehot_bad, 0);
    chk({tag, " done_fail_excl"}, flag_bad, 0);
    chk({tag, " wdata"}, wdata_bad, 0);
  endtask

  // ---------------- test sequence -----------------------------------------
  initial begin
    int cyc;
    maze_fill(0);
    do_reset();
    env_clr = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst fail", int'(fail), 0);
    chk("rst cur_loc", int'(cur_loc), 0);
    chk("rst strobes", int'({mem_rd, mem_wr, stk_push, stk_pop, move}), 0);
    chk("rst mem_addr", int'(mem_addr), 0);
`ifdef MAZE_DFS_STEP_CNT_EN
    chk("rst step_cnt", int'(step_cnt), 0);
`endif

    // Open maze: 30 forward steps along row 0 then column 15
    maze_fill(0);
    run_case("open", 256);
    chk("open moves30", mv_cnt, 30);

    // Start enclosed by walls
    maze_fill(0);
    maze_init[8'h01] = 1'b1;
    maze_init[8'h10] = 1'b1;
    run_case("enclosed", 256);
    chk("enclosed fail", int'(fail), 1);
    chk("enclosed moves0", mv_cnt, 0);

    // Dead-end corridor 0x00 -> 0x01 -> 0x02
    maze_fill(0);
    maze_init[8'h03] = 1'b1;
    maze_init[8'h11] = 1'b1;
    maze_init[8'h12] = 1'b1;
    run_case("deadend", 256);
    chk("deadend pops2", pop_cnt, 2);
    chk("deadend done", int'(done), 1);

    // Stack full at the first advance
    maze_fill(0);
    run_case("stkfull", 0);
    chk("stkfull pushes0", push_cnt, 0);

    // Reset asserted while in READ mid-search
    maze_fill(0);
    load_env(256);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(mem_rd && rd_cnt >= 6) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst reach_read", int'(cyc >= 2000), 0);
    chk("midrst cur_loc_moved", int'(cur_loc != 8'h00), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", int'(busy), 0);
    chk("midrst cur_loc", int'(cur_loc), 0);
    chk("midrst strobes", int'({mem_rd, mem_wr, stk_push, stk_pop, move}), 0);
    chk("midrst flags", int'({done, fail}), 0);
`ifdef MAZE_DFS_STEP_CNT_EN
    chk("midrst step_cnt", int'(step_cnt), 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    run_case("after_rst", 256);

    // Start held high through DONE restarts immediately
    maze_fill(0);
    load_env(256);
    start = 1'b1;
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("hold reach_done", int'(cyc >= 5000), 0);
    @(negedge clk);
    chk("hold done_clr", int'(done), 0);
    chk("hold busy", int'(busy), 1);
`ifdef MAZE_DFS_STEP_CNT_EN
    chk("hold step_cnt", int'(step_cnt), 0);
`endif
    start = 1'b0;
    do_reset();

    // Random mazes against the reference model
    for (int t = 0; t < 8; t++) begin
      int depth;
      for (int i = 0; i < 256; i++) maze_init[i] = ($urandom_range(0, 99) < 30);
      maze_init[0]   = 1'b0;
      maze_init[255] = 1'b0;
      depth = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 256;
      run_case($sformatf("rand%0d", t), depth);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
